// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared encodings for the instruction fetch unit
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int NSEL_RN = 2;
  localparam int NSEL_RD = 1;
  localparam int NSEL_RM = 0;

endpackage

// File: rtl/instr_dec.sv
// rtl/instr_dec.sv - combinational instruction field decode and register select
module instr_dec
  import instr_fetch_unit_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nsel,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  logic [2:0] rn, rd, rm, reg_sel;
  logic       is_mem_op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  // Loads and stores reuse IR[4:3] as offset bits, so the shifter must stay idle.
  assign is_mem_op = (opcode == OP_LDR) || (opcode == OP_STR);
  assign shift     = is_mem_op ? 2'b00 : ir[4:3];

  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  assign reg_sel = (rn & {3{nsel[NSEL_RN]}})
                 | (rd & {3{nsel[NSEL_RD]}})
                 | (rm & {3{nsel[NSEL_RM]}});

  assign readnum  = reg_sel;
  assign writenum = reg_sel;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, IR and data address registers with memory interface
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int MEM_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reset_pc,
  input  logic            load_pc,
  input  logic            load_ir,
  input  logic            load_addr,
  input  logic            addr_sel,
  input  logic [1:0]      mem_cmd,
  input  logic [2:0]      nsel,
  input  logic [15:0]     datapath_out,
  input  logic [15:0]     read_data,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_write,
  output logic            mem_read,
  output logic [15:0]     write_data,
  output logic            mem_err,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic [1:0]      shift,
  output logic [15:0]     sximm5,
  output logic [15:0]     sximm8
);

  // One extra bit so MEM_WORDS == 2**PC_W still compares correctly.
  localparam logic [PC_W:0] MEM_LIMIT = MEM_WORDS[PC_W:0];

  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [PC_W-1:0] addr_q;
  logic            in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      ir_q   <= '0;
      addr_q <= '0;
    end else begin
      if (load_pc)   pc_q   <= reset_pc ? '0 : pc_q + PC_W'(1);
      if (load_ir)   ir_q   <= read_data;
      if (load_addr) addr_q <= datapath_out[PC_W-1:0];
    end
  end

  assign pc         = pc_q;
  assign mem_addr   = addr_sel ? pc_q : addr_q;
  assign write_data = datapath_out;

  assign in_range  = {1'b0, mem_addr} < MEM_LIMIT;
  assign mem_read  = (mem_cmd == MREAD)  &&  in_range;
  assign mem_write = (mem_cmd == MWRITE) &&  in_range;
  assign mem_err   = ((mem_cmd == MREAD) || (mem_cmd == MWRITE)) && !in_range;

  instr_dec u_dec (
    .ir       (ir_q),
    .nsel     (nsel),
    .opcode   (opcode),
    .op       (op),
    .readnum  (readnum),
    .writenum (writenum),
    .shift    (shift),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, reset_pc, load_pc, load_ir, load_addr, addr_sel;
  logic [1:0]  mem_cmd;
  logic [2:0]  nsel;
  logic [15:0] datapath_out, read_data;
  logic [8:0]  mem_addr, pc;
  logic        mem_write, mem_read, mem_err;
  logic [15:0] write_data, sximm5, sximm8;
  logic [2:0]  opcode, readnum, writenum;
  logic [1:0]  op, shift;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(9), .MEM_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .reset_pc     (reset_pc),
    .load_pc      (load_pc),
    .load_ir      (load_ir),
    .load_addr    (load_addr),
    .addr_sel     (addr_sel),
    .mem_cmd      (mem_cmd),
    .nsel         (nsel),
    .datapath_out (datapath_out),
    .read_data    (read_data),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .write_data   (write_data),
    .mem_err      (mem_err),
    .pc           (pc),
    .opcode       (opcode),
    .op           (op),
    .readnum      (readnum),
    .writenum     (writenum),
    .shift        (shift),
    .sximm5       (sximm5),
    .sximm8       (sximm8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_loads();
    reset = 0; reset_pc = 0; load_pc = 0; load_ir = 0; load_addr = 0;
  endtask

  initial begin
    idle_loads();
    addr_sel = 1; mem_cmd = 2'b00; nsel = 3'b000;
    datapath_out = 16'h0000; read_data = 16'h0000;
    #2;
    reset = 1;
    step();
    reset = 0;

    // reset state
    check("rst_pc", pc, 0);
    check("rst_opcode", opcode, 0);
    check("rst_op", op, 0);
    check("rst_shift", shift, 0);
    check("rst_sximm5", sximm5, 0);
    check("rst_sximm8", sximm8, 0);
    check("rst_readnum", readnum, 0);
    mem_cmd = 2'b01; #1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_read", mem_read, 1);
    check("rst_mem_err", mem_err, 0);
    mem_cmd = 2'b00;

    // PC increment and reset_pc
    load_pc = 1;
    repeat (3) step();
    check("pc_inc3", pc, 3);
    reset_pc = 1; step();
    check("pc_reset_pc", pc, 0);
    reset_pc = 0; step();
    check("pc_inc1", pc, 1);
    load_pc = 0; reset_pc = 1; step(); step();
    check("pc_hold", pc, 1);
    reset_pc = 0;

    // wrap from 511
    reset = 1; step(); reset = 0;
    load_pc = 1;
    repeat (511) step();
    check("pc_511", pc, 511);
    step();
    check("pc_wrap", pc, 0);
    load_pc = 0;

    // IR decode A0FF
    read_data = 16'hA0FF; load_ir = 1; step(); load_ir = 0;
    check("a0ff_opcode", opcode, 3'b101);
    check("a0ff_op", op, 2'b00);
    check("a0ff_sximm8", sximm8, 16'hFFFF);
    check("a0ff_sximm5", sximm5, 16'hFFFF);
    check("a0ff_shift", shift, 2'b11);
    nsel = 3'b100; #1;
    check("a0ff_rn", readnum, 3'b000);
    nsel = 3'b010; #1;
    check("a0ff_rd_read", readnum, 3'b111);
    check("a0ff_rd_write", writenum, 3'b111);

    // IR decode 1A6C: op=11 Rn=010 Rd=011 shift=01 Rm=100
    read_data = 16'h1A6C; load_ir = 1; step(); load_ir = 0;
    check("1a6c_opcode", opcode, 3'b000);
    check("1a6c_op", op, 2'b11);
    check("1a6c_shift", shift, 2'b01);
    check("1a6c_sximm5", sximm5, 16'h000C);
    check("1a6c_sximm8", sximm8, 16'h006C);
    nsel = 3'b001; #1;
    check("1a6c_rm", readnum, 3'b100);
    nsel = 3'b101; #1;
    check("1a6c_rn_or_rm", writenum, 3'b110);
    nsel = 3'b111; #1;
    check("1a6c_all", readnum, 3'b111);
    nsel = 3'b000; #1;
    check("1a6c_none", readnum, 3'b000);
    read_data = 16'hFFFF; step();
    check("ir_hold", opcode, 3'b000);

    // data address and memory strobes
    datapath_out = 16'h0123; load_addr = 1; step(); load_addr = 0;
    addr_sel = 0; mem_cmd = 2'b10; #1;
    check("oor_mem_addr", mem_addr, 9'h123);
    check("oor_mem_write", mem_write, 0);
    check("oor_mem_err", mem_err, 1);
    check("write_data", write_data, 16'h0123);
    mem_cmd = 2'b11; #1;
    check("rsv_mem_err", mem_err, 0);
    check("rsv_mem_write", mem_write, 0);
    datapath_out = 16'h0042; load_addr = 1; step(); load_addr = 0;
    mem_cmd = 2'b10; #1;
    check("ir_mem_write", mem_write, 1);
    check("ir_mem_err", mem_err, 0);
    mem_cmd = 2'b01; #1;
    check("ir_mem_read", mem_read, 1);
    datapath_out = 16'h00FF; load_addr = 1; step(); load_addr = 0; #1;
    check("edge_ff_read", mem_read, 1);
    datapath_out = 16'h0100; load_addr = 1; step(); load_addr = 0; #1;
    check("edge_100_read", mem_read, 0);
    check("edge_100_err", mem_err, 1);
    addr_sel = 1; #1;
    check("sel_pc_addr", mem_addr, 0);
    check("sel_pc_read", mem_read, 1);
    mem_cmd = 2'b00;

    // shift forcing for LDR/STR
    read_data = 16'h6018; load_ir = 1; step();
    check("ldr_shift", shift, 2'b00);
    read_data = 16'h8018; step();
    check("str_shift", shift, 2'b00);
    read_data = 16'hA018; step(); load_ir = 0;
    check("alu_shift", shift, 2'b11);

    // simultaneous independent loads
    load_pc = 1; load_ir = 1; load_addr = 1;
    read_data = 16'hC0AB; datapath_out = 16'h0155; step();
    idle_loads();
    addr_sel = 0; #1;
    check("multi_pc", pc, 1);
    check("multi_opcode", opcode, 3'b110);
    check("multi_addr", mem_addr, 9'h155);

    // reset overrides all loads
    reset = 1; load_pc = 1; load_ir = 1; load_addr = 1;
    read_data = 16'hFFFF; datapath_out = 16'h01FF; step();
    idle_loads();
    check("rstov_pc", pc, 0);
    check("rstov_opcode", opcode, 0);
    check("rstov_sximm8", sximm8, 0);
    check("rstov_addr", mem_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning program counter and memory address width in bits.
REQ-002 SHALL have parameter MEM_WORDS, default 256, meaning number of implemented memory words; addresses at or above it are out of range.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reset_pc  input  1  selects zero as next PC value instead of PC+1.
REQ-006 load_pc  input  1  PC register load enable.
REQ-007 load_ir  input  1  instruction register load enable.
REQ-008 load_addr  input  1  data address register load enable.
REQ-009 addr_sel  input  1  1 selects PC, 0 selects data address, as the memory address.
REQ-010 mem_cmd  input  2  memory command: 00 none, 01 read, 10 write, 11 reserved.
REQ-011 nsel  input  3  register select: bit2 Rn, bit1 Rd, bit0 Rm.
REQ-012 datapath_out  input  16  datapath result; source of data address and store data.
REQ-013 read_data  input  16  memory read data.
REQ-014 mem_addr  output  PC_W  memory address.
REQ-015 mem_write  output  1  memory write strobe.
REQ-016 mem_read  output  1  memory read enable.
REQ-017 write_data  output  16  store data to memory.
REQ-018 mem_err  output  1  read or write command to an out-of-range address.
REQ-019 pc  output  PC_W  current PC value.
REQ-020 opcode  output  3  IR[15:13], consumed by the state machine controller.
REQ-021 op  output  2  IR[12:11], consumed by the state machine controller and as the ALU op.
REQ-022 readnum, writenum  output  3 each  register number selected by nsel.
REQ-023 shift  output  2  shift code.
REQ-024 sximm5, sximm8  output  16 each  sign-extended IR[4:0] and IR[7:0].

Function
REQ-025 PC SHALL load (reset_pc ? 0 : pc+1) on a clock edge with load_pc=1; it SHALL hold when load_pc=0, regardless of reset_pc.
REQ-026 PC increment SHALL wrap modulo 2^PC_W (all ones -> 0).
REQ-027 IR SHALL load read_data on a clock edge with load_ir=1, and SHALL hold otherwise.
REQ-028 Data address register SHALL load datapath_out[PC_W-1:0] on a clock edge with load_addr=1, and SHALL hold otherwise.
REQ-029 Loads of PC, IR and data address SHALL be independent; any combination may occur in one cycle.
REQ-030 mem_addr SHALL equal addr_sel ? pc : data address, combinationally.
REQ-031 mem_read SHALL be 1 iff mem_cmd=01 and mem_addr<MEM_WORDS.
REQ-032 mem_write SHALL be 1 iff mem_cmd=10 and mem_addr<MEM_WORDS.
REQ-033 mem_err SHALL be 1 iff mem_cmd is 01 or 10 and mem_addr>=MEM_WORDS; mem_cmd=11 SHALL drive mem_read=mem_write=mem_err=0.
REQ-034 write_data SHALL equal datapath_out combinationally.
REQ-035 The decode SHALL use the IR fields: Rn=IR[10:8], Rd=IR[7:5], shift=IR[4:3], Rm=IR[2:0].
REQ-036 readnum and writenum SHALL equal the bitwise OR of each field ANDed with its nsel bit; nsel=000 SHALL yield 000.
REQ-037 shift SHALL be forced to 00 when opcode is 011 (LDR) or 100 (STR).
REQ-038 All decode outputs SHALL be combinational from IR and nsel, with no extra latency; an IR load is visible the cycle after the load edge.

Reset
REQ-039 When reset=1 at a clock edge, PC, IR and data address SHALL clear to 0, overriding all load enables.
REQ-040 After reset: pc=0, opcode=000, op=00, shift=00, sximm5=sximm8=0; memory outputs SHALL follow mem_cmd/addr_sel per REQ-030..033.

Structure
REQ-041 The shared package SHALL hold the MNONE/MREAD/MWRITE encodings, the opcode constants (MOV 110, ALU 101, LDR 011, STR 100, HALT 111) and the nsel bit positions.
REQ-042 Field extraction, sign extension and nsel muxing SHALL be a combinational sub-module instr_dec; all registers SHALL be in instr_fetch_unit.

Verification
REQ-043 Apply reset, then load_pc=1 with reset_pc=0 for 3 cycles -> pc=3; then load_pc=1 with reset_pc=1 -> pc=0.
REQ-044 Preload pc=511, then load_pc=1 -> pc=0 (wrap).
REQ-045 Set read_data=16'hA0FF with load_ir=1 -> opcode=101, op=00, Rn=000, sximm8=16'hFFFF; then nsel=010 -> readnum=111.
REQ-046 Set datapath_out=16'h0123 with load_addr=1, then addr_sel=0, mem_cmd=10 -> mem_addr=9'h123, mem_write=0, mem_err=1; with datapath_out=16'h0042 -> mem_write=1, mem_err=0.
REQ-047 Load IR=16'h6018 (LDR) -> shift=00; load IR=16'hA018 -> shift=11.
REQ-048 Assert reset together with load_pc, load_ir and load_addr -> pc, IR and data address all 0 at the next edge.
